scr1_dmem_y_arb: RTL and testbench
==================================

Name: scr1_dmem_y_arb

Overview:
Two-requester arbiter that shares the single wide (`YTYDLA_LSU_WIDTH) data-memory port. Requester 0 is the highspeed LSU; requester 1 is the YTYDLA prefetch/DMA engine. It forwards one request per handshake with round-robin fairness, holds the grant stable until the handshake completes, and tracks up to OUTSTD_MAX outstanding transactions. Responses are returned in order to the requester that issued them.

Parameters:
OUTSTD_MAX, 2, maximum accepted-but-unanswered transactions (1..4); sets owner-FIFO depth.
CNT_W, $clog2(OUTSTD_MAX+1), width of the outstanding counter (derived, do not override).

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
req0_req / req1_req  in  1  request from requester 0 / 1; held with its payload stable until its req_ack
req0_cmd / req1_cmd  in  type_scr1_mem_cmd_e  RD/WR
req0_width / req1_width  in  type_scr1_mem_y_width_e  FIVE_WORD / THREE_WORD
req0_addr / req1_addr  in  `SCR1_DMEM_AWIDTH  address
req0_wdata / req1_wdata  in  `YTYDLA_LSU_WIDTH  store data
req0_req_ack / req1_req_ack  out  1  request accepted this cycle
req0_rdata / req1_rdata  out  `YTYDLA_LSU_WIDTH  load data; zero unless that port's resp is not NOTRDY
req0_resp / req1_resp  out  type_scr1_mem_resp_e  routed response
arb2dmem_req  out  1  forwarded request
arb2dmem_cmd, arb2dmem_width, arb2dmem_addr, arb2dmem_wdata  out  as above  payload of the granted requester
dmem2arb_req_ack  in  1  memory accepts the request
dmem2arb_rdata  in  `YTYDLA_LSU_WIDTH  read data
dmem2arb_resp  in  type_scr1_mem_resp_e  NOTRDY / RDY_OK / RDY_ER
arb_busy  out  1  outstanding count != 0
arb_spurious_resp  out  1  one-cycle pulse: response received while the outstanding count is 0

Behaviour:
- Reset (rst=1 at a clock edge): state=ARB_IDLE, rr_ptr=0 (port 0 has priority), count=0, owner FIFO emptied. While rst=1, all outputs are forced inactive: acks 0, arb2dmem_req 0, resp NOTRDY, rdata 0, busy 0, spurious 0.
- Handshake: an accept occurs when arb2dmem_req & dmem2arb_req_ack in the same cycle. req_ack goes to the granted port only and is combinational from dmem2arb_req_ack (zero latency).
- FSM states:
  - ARB_IDLE: winner = requester with a request; if both request, winner = rr_ptr. If count < OUTSTD_MAX, drive arb2dmem_* from the winner. On accept, stay in IDLE. If not accepted, latch gnt_id=winner and go to ARB_WAIT.
  - ARB_WAIT: drive strictly from gnt_id, ignoring the other port and rr_ptr. On accept, go to IDLE. If the gnt_id request drops (protocol violation), go to IDLE with no accept.
- Full condition: count == OUTSTD_MAX forces arb2dmem_req=0 and all acks 0; state is held. A pop in the same cycle does not enable a push; this deliberately avoids a resp-to-req combinational path.
- On accept: push the winner id into the owner FIFO, count++, and rr_ptr <= ~winner.
- Response: when dmem2arb_resp != NOTRDY and count > 0, route resp and rdata to the FIFO head owner, pop, count--. The other port sees NOTRDY and rdata 0. RDY_ER is routed like RDY_OK.
- Simultaneous accept and response in one cycle: push and pop both happen, count unchanged. The FIFO pointers wrap modulo OUTSTD_MAX.
- Response with count == 0: dropped, arb_spurious_resp=1 for that cycle, no state change. This also covers responses arriving after a mid-operation reset.
- Single requester: no bubbles; back-to-back accepts are allowed every cycle up to the full limit.

Test Plan:
- Reset, then only req0 (RD, FIVE_WORD, addr 0x100) with dmem ack=1 → req0_req_ack=1 same cycle, arb2dmem_addr=0x100, count=1; RDY_OK next cycle with rdata=0xA5.. → req0_resp=RDY_OK, req0_rdata=0xA5.., req1_resp=NOTRDY.
- req0 and req1 held continuously, ack=1, immediate responses → grants alternate 0,1,0,1; rr_ptr starts at 0.
- Both request, ack=0 for 3 cycles with port 0 granted, then ack=1 → arb2dmem_addr stays port 0's for all 4 cycles; port 1 is granted next.
- OUTSTD_MAX=2: two accepts with no response → third request sees arb2dmem_req=0; after one RDY_ER, the error goes to the first owner and the next accept proceeds.
- Accept from port 1 in the same cycle as a response for port 0 → count unchanged, FIFO ordering correct, wrap verified over 10 transactions.
- RDY_OK with count=0 → arb_spurious_resp pulses 1 cycle, both resp NOTRDY. Assert rst mid-flight → count=0, subsequent response flagged spurious.

Source files
------------

// File: rtl/scr1_dmem_y_arb.sv
// ---------------------------------------------------------------------------
// scr1_dmem_y_arb
// Two-requester arbiter in front of the single wide data-memory port.
// Requester 0 is the highspeed LSU, requester 1 is the YTYDLA prefetch/DMA
// engine. One request is forwarded per handshake with round-robin fairness,
// a stalled grant is held until its handshake completes, and an owner FIFO
// routes in-order responses back to the requester that issued them.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   reqN_req                 request from requester N, held until reqN_req_ack
//   reqN_cmd/width/addr/wdata  payload of requester N
//   reqN_req_ack             request of N accepted this cycle
//   reqN_rdata/resp          response routed back to requester N
//   arb2dmem_*               forwarded request and payload of the winner
//   dmem2arb_req_ack         memory accepts the forwarded request
//   dmem2arb_rdata/resp      in-order response from memory
//   arb_busy                 at least one transaction outstanding
//   arb_spurious_resp        response seen with nothing outstanding
//
// Encodings: cmd RD=0/WR=1, width FIVE_WORD=0/THREE_WORD=1,
//            resp NOTRDY=0/RDY_OK=1/RDY_ER=2.
// ---------------------------------------------------------------------------
`ifndef YTYDLA_LSU_WIDTH
`define YTYDLA_LSU_WIDTH 160
`endif
`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif

module scr1_dmem_y_arb #(
   parameter int OUTSTD_MAX = 2,
   parameter int CNT_W      = $clog2(OUTSTD_MAX + 1)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           req0_req,
   input  logic                           req0_cmd,
   input  logic                           req0_width,
   input  logic [`SCR1_DMEM_AWIDTH-1:0]   req0_addr,
   input  logic [`YTYDLA_LSU_WIDTH-1:0]   req0_wdata,
   output logic                           req0_req_ack,
   output logic [`YTYDLA_LSU_WIDTH-1:0]   req0_rdata,
   output logic [1:0]                     req0_resp,
   input  logic                           req1_req,
   input  logic                           req1_cmd,
   input  logic                           req1_width,
   input  logic [`SCR1_DMEM_AWIDTH-1:0]   req1_addr,
   input  logic [`YTYDLA_LSU_WIDTH-1:0]   req1_wdata,
   output logic                           req1_req_ack,
   output logic [`YTYDLA_LSU_WIDTH-1:0]   req1_rdata,
   output logic [1:0]                     req1_resp,
   output logic                           arb2dmem_req,
   output logic                           arb2dmem_cmd,
   output logic                           arb2dmem_width,
   output logic [`SCR1_DMEM_AWIDTH-1:0]   arb2dmem_addr,
   output logic [`YTYDLA_LSU_WIDTH-1:0]   arb2dmem_wdata,
   input  logic                           dmem2arb_req_ack,
   input  logic [`YTYDLA_LSU_WIDTH-1:0]   dmem2arb_rdata,
   input  logic [1:0]                     dmem2arb_resp,
   output logic                           arb_busy,
   output logic                           arb_spurious_resp
);

   localparam int               PTR_W       = (OUTSTD_MAX > 1) ? $clog2(OUTSTD_MAX) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(OUTSTD_MAX);
   localparam logic [PTR_W-1:0] PTR_LAST    = PTR_W'(OUTSTD_MAX - 1);
   localparam logic [1:0]       RESP_NOTRDY = 2'd0;

   typedef enum logic {
      ARB_IDLE,
      ARB_WAIT
   } arb_state_e;

   arb_state_e       state, state_next;
   logic             rr_ptr;
   logic             gnt_id, gnt_id_next;
   logic             winner;
   logic             winner_req;
   logic             fwd;
   logic             full;
   logic             accept;
   logic             resp_vld;
   logic             pop;
   logic             owner;
   logic [CNT_W-1:0] count;
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic             owner_fifo [OUTSTD_MAX];

   // Pushing is blocked on the registered count only, so a same-cycle pop
   // never opens a path from the response to the request side.
   assign full = (count == CNT_MAX);

   // Winner selection and next state. In WAIT the latched grant is honoured
   // exclusively so the memory sees a stable payload until it accepts.
   always_comb begin
      state_next  = state;
      gnt_id_next = gnt_id;
      winner      = 1'b0;
      fwd         = 1'b0;
      case (state)
         ARB_IDLE: begin
            winner = (req0_req & req1_req) ? rr_ptr : req1_req;
            fwd    = (req0_req | req1_req) & ~full;
            if (fwd & ~dmem2arb_req_ack) begin
               state_next  = ARB_WAIT;
               gnt_id_next = winner;
            end
         end
         ARB_WAIT: begin
            winner = gnt_id;
            fwd    = winner_req & ~full;
            if (!full) begin
               // A dropped request is a protocol violation; recover to IDLE.
               if ((fwd & dmem2arb_req_ack) | ~winner_req) begin
                  state_next = ARB_IDLE;
               end
            end
         end
         default: state_next = ARB_IDLE;
      endcase
   end

   assign winner_req = gnt_id ? req1_req : req0_req;

   assign arb2dmem_req   = fwd & ~rst;
   assign arb2dmem_cmd   = winner ? req1_cmd   : req0_cmd;
   assign arb2dmem_width = winner ? req1_width : req0_width;
   assign arb2dmem_addr  = winner ? req1_addr  : req0_addr;
   assign arb2dmem_wdata = winner ? req1_wdata : req0_wdata;

   assign accept       = arb2dmem_req & dmem2arb_req_ack;
   assign req0_req_ack = accept & ~winner;
   assign req1_req_ack = accept & winner;

   // Responses go to the FIFO head owner; a response with nothing
   // outstanding is dropped and flagged instead.
   assign resp_vld          = ~rst & (dmem2arb_resp != RESP_NOTRDY);
   assign pop               = resp_vld & (count != '0);
   assign arb_spurious_resp = resp_vld & (count == '0);
   assign owner             = owner_fifo[rd_ptr];

   assign req0_resp  = (pop & ~owner) ? dmem2arb_resp  : RESP_NOTRDY;
   assign req1_resp  = (pop &  owner) ? dmem2arb_resp  : RESP_NOTRDY;
   assign req0_rdata = (pop & ~owner) ? dmem2arb_rdata : '0;
   assign req1_rdata = (pop &  owner) ? dmem2arb_rdata : '0;
   assign arb_busy   = ~rst & (count != '0);

   // State register, fairness pointer, FIFO pointers and outstanding count.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ARB_IDLE;
         gnt_id <= 1'b0;
         rr_ptr <= 1'b0;
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         state  <= state_next;
         gnt_id <= gnt_id_next;
         if (accept) begin
            rr_ptr <= ~winner;
            wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
         end
         case ({accept, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Owner storage needs no reset: entries are only read once pushed.
   always_ff @(posedge clk) begin
      if (accept) begin
         owner_fifo[wr_ptr] <= winner;
      end
   end

endmodule

// File: tb/tb_scr1_dmem_y_arb.sv
// ---------------------------------------------------------------------------
// tb_scr1_dmem_y_arb
// Bench for scr1_dmem_y_arb: directed scenarios with literal expectations,
// followed by randomized traffic compared every cycle against a queue-based
// reference model of the arbiter.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`ifndef YTYDLA_LSU_WIDTH
`define YTYDLA_LSU_WIDTH 160
`endif
`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif

module tb_scr1_dmem_y_arb;

   localparam int         OMAX     = 2;
   localparam int         DW       = `YTYDLA_LSU_WIDTH;
   localparam int         AW       = `SCR1_DMEM_AWIDTH;
   localparam logic [1:0] R_NOTRDY = 2'd0;
   localparam logic [1:0] R_OK     = 2'd1;
   localparam logic [1:0] R_ER     = 2'd2;

   logic          clk;
   logic          rst;
   logic [1:0]    b_req;
   logic [1:0]    b_cmd;
   logic [1:0]    b_width;
   logic [AW-1:0] b_addr  [2];
   logic [DW-1:0] b_wdata [2];
   logic          b_ack;
   logic [DW-1:0] b_rdata;
   logic [1:0]    b_resp;

   logic          req0_req_ack, req1_req_ack;
   logic [DW-1:0] req0_rdata, req1_rdata;
   logic [1:0]    req0_resp, req1_resp;
   logic          arb2dmem_req, arb2dmem_cmd, arb2dmem_width;
   logic [AW-1:0] arb2dmem_addr;
   logic [DW-1:0] arb2dmem_wdata;
   logic          arb_busy, arb_spurious_resp;

   scr1_dmem_y_arb #(.OUTSTD_MAX(OMAX)) dut (
      .clk               (clk),
      .rst               (rst),
      .req0_req          (b_req[0]),
      .req0_cmd          (b_cmd[0]),
      .req0_width        (b_width[0]),
      .req0_addr         (b_addr[0]),
      .req0_wdata        (b_wdata[0]),
      .req0_req_ack      (req0_req_ack),
      .req0_rdata        (req0_rdata),
      .req0_resp         (req0_resp),
      .req1_req          (b_req[1]),
      .req1_cmd          (b_cmd[1]),
      .req1_width        (b_width[1]),
      .req1_addr         (b_addr[1]),
      .req1_wdata        (b_wdata[1]),
      .req1_req_ack      (req1_req_ack),
      .req1_rdata        (req1_rdata),
      .req1_resp         (req1_resp),
      .arb2dmem_req      (arb2dmem_req),
      .arb2dmem_cmd      (arb2dmem_cmd),
      .arb2dmem_width    (arb2dmem_width),
      .arb2dmem_addr     (arb2dmem_addr),
      .arb2dmem_wdata    (arb2dmem_wdata),
      .dmem2arb_req_ack  (b_ack),
      .dmem2arb_rdata    (b_rdata),
      .dmem2arb_resp     (b_resp),
      .arb_busy          (arb_busy),
      .arb_spurious_resp (arb_spurious_resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: owners of outstanding transactions in issue order,
   // the fairness preference, and a lock on a stalled grant.
   bit   q[$];
   bit   m_rr;
   bit   m_lock;
   bit   m_lock_id;
   bit   e_fwd, e_w, e_acc, e_pop;
   bit   pend [2];
   int   n_checks = 0;
   int   n_pass   = 0;

   function automatic logic [DW-1:0] rand_wide();
      logic [DW-1:0] v;
      v = '0;
      for (int i = 0; i < DW; i += 32) v = (v << 32) | DW'($urandom);
      return v;
   endfunction

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Compare all DUT outputs against what the model says they must be for
   // the inputs currently applied.
   task automatic checkOutput();
      logic [1:0]    e_resp0, e_resp1;
      logic [DW-1:0] e_rd0, e_rd1;
      bit            full, resp_v, e_spur, e_busy, own;
      e_fwd = 0; e_w = 0; e_acc = 0; e_pop = 0; e_spur = 0; e_busy = 0;
      e_resp0 = R_NOTRDY; e_resp1 = R_NOTRDY; e_rd0 = '0; e_rd1 = '0;
      if (!rst) begin
         full = (q.size() == OMAX);
         if (m_lock) begin
            e_w   = m_lock_id;
            e_fwd = b_req[m_lock_id] && !full;
         end else begin
            e_w   = (b_req == 2'b11) ? m_rr : b_req[1];
            e_fwd = (b_req != 2'b00) && !full;
         end
         e_acc  = e_fwd && b_ack;
         resp_v = (b_resp != R_NOTRDY);
         e_pop  = resp_v && (q.size() > 0);
         e_spur = resp_v && (q.size() == 0);
         e_busy = (q.size() != 0);
         if (e_pop) begin
            own = q[0];
            if (own) begin e_resp1 = b_resp; e_rd1 = b_rdata; end
            else     begin e_resp0 = b_resp; e_rd0 = b_rdata; end
         end
      end
      check("arb2dmem_req", arb2dmem_req, e_fwd);
      check("req0_req_ack", req0_req_ack, e_acc && !e_w);
      check("req1_req_ack", req1_req_ack, e_acc && e_w);
      check("req0_resp", req0_resp, e_resp0);
      check("req1_resp", req1_resp, e_resp1);
      check("req0_rdata", req0_rdata, e_rd0);
      check("req1_rdata", req1_rdata, e_rd1);
      check("arb_busy", arb_busy, e_busy);
      check("arb_spurious_resp", arb_spurious_resp, e_spur);
      if (e_fwd) begin
         check("arb2dmem_cmd", arb2dmem_cmd, b_cmd[e_w]);
         check("arb2dmem_width", arb2dmem_width, b_width[e_w]);
         check("arb2dmem_addr", arb2dmem_addr, b_addr[e_w]);
         check("arb2dmem_wdata", arb2dmem_wdata, b_wdata[e_w]);
      end
   endtask

   task automatic modelUpdate();
      if (rst) begin
         q.delete();
         m_rr = 0;
         m_lock = 0;
      end else begin
         if (e_pop) void'(q.pop_front());
         if (e_acc) begin
            q.push_back(e_w);
            m_rr   = !e_w;
            m_lock = 0;
         end else if (e_fwd) begin
            m_lock    = 1;
            m_lock_id = e_w;
         end else if (m_lock && (q.size() < OMAX) && !b_req[m_lock_id]) begin
            m_lock = 0;
         end
      end
   endtask

   // Inputs are applied 1ns after the rising edge and outputs are sampled
   // on the falling edge.
   task automatic settle();
      #4;
      checkOutput();
   endtask

   task automatic advance();
      @(posedge clk);
      modelUpdate();
      #1;
   endtask

   task automatic setReq(input int p, input logic [AW-1:0] addr);
      b_req[p]   = 1'b1;
      b_cmd[p]   = 1'($urandom);
      b_width[p] = 1'($urandom);
      b_addr[p]  = addr;
      b_wdata[p] = rand_wide();
   endtask

   task automatic idleInputs();
      b_req = 2'b00; b_ack = 1'b0; b_resp = R_NOTRDY; b_rdata = rand_wide();
      pend[0] = 0; pend[1] = 0;
   endtask

   task automatic doReset();
      rst = 1'b1;
      idleInputs();
      for (int i = 0; i < 2; i++) begin settle(); advance(); end
      rst = 1'b0;
   endtask

   task automatic applyStimulus(input int ack_pct, input int resp_pct);
      for (int p = 0; p < 2; p++) begin
         if (!pend[p] && ($urandom_range(99) < 60)) begin
            pend[p] = 1;
            setReq(p, AW'($urandom));
         end
      end
      b_ack   = ($urandom_range(99) < ack_pct);
      b_rdata = rand_wide();
      if ($urandom_range(99) < resp_pct) b_resp = ($urandom_range(3) == 0) ? R_ER : R_OK;
      else                               b_resp = R_NOTRDY;
   endtask

   initial begin
      logic [DW-1:0] pat_a5;
      pat_a5 = {(DW/8){8'hA5}};
      rst = 1'b1;
      b_cmd = 2'b00; b_width = 2'b00;
      b_addr[0] = '0; b_addr[1] = '0; b_wdata[0] = '0; b_wdata[1] = '0;
      idleInputs();
      doReset();

      // Single LSU read, then its response routed back.
      setReq(0, 32'h100);
      b_cmd[0] = 1'b0; b_width[0] = 1'b0; b_ack = 1'b1;
      settle();
      check("t1_ack0", req0_req_ack, 1'b1);
      check("t1_addr", arb2dmem_addr, 32'h100);
      advance();
      b_req = 2'b00; b_ack = 1'b0; b_resp = R_OK; b_rdata = pat_a5;
      settle();
      check("t1_resp0", req0_resp, R_OK);
      check("t1_rdata0", req0_rdata, pat_a5);
      check("t1_resp1", req1_resp, R_NOTRDY);
      advance();

      // Response with nothing outstanding is flagged for one cycle.
      b_resp = R_OK; b_rdata = rand_wide();
      settle();
      check("spur_flag", arb_spurious_resp, 1'b1);
      check("spur_resp0", req0_resp, R_NOTRDY);
      advance();
      b_resp = R_NOTRDY;
      settle();
      check("spur_clear", arb_spurious_resp, 1'b0);
      advance();

      // Both requesters held, immediate acceptance: grants alternate 0,1,0,1.
      doReset();
      setReq(0, 32'h1000); setReq(1, 32'h2000); b_ack = 1'b1;
      for (int k = 0; k < 4; k++) begin
         settle();
         check("alt_ack0", req0_req_ack, (k % 2) == 0);
         check("alt_ack1", req1_req_ack, (k % 2) == 1);
         advance();
         setReq(k % 2, AW'($urandom));
         b_resp = R_OK; b_rdata = rand_wide();
      end

      // Stalled grant keeps port 0's payload; port 1 wins next.
      doReset();
      setReq(0, 32'h200); setReq(1, 32'h300);
      for (int k = 0; k < 4; k++) begin
         b_ack = (k == 3);
         settle();
         check("wait_addr", arb2dmem_addr, 32'h200);
         check("wait_ack0", req0_req_ack, k == 3);
         advance();
      end
      setReq(0, 32'h204); b_ack = 1'b1;
      settle();
      check("wait_next_ack1", req1_req_ack, 1'b1);
      check("wait_next_addr", arb2dmem_addr, 32'h300);
      advance();

      // Outstanding limit, error routed to the first owner, then progress.
      doReset();
      setReq(0, 32'h10); b_ack = 1'b1;
      settle(); check("full_acc1", req0_req_ack, 1'b1); advance();
      setReq(0, 32'h14);
      settle(); check("full_acc2", req0_req_ack, 1'b1); advance();
      b_req[0] = 1'b0; setReq(1, 32'h20);
      settle();
      check("full_blocked", arb2dmem_req, 1'b0);
      check("full_busy", arb_busy, 1'b1);
      advance();
      b_resp = R_ER; b_rdata = rand_wide();
      settle();
      check("full_err0", req0_resp, R_ER);
      check("full_err1", req1_resp, R_NOTRDY);
      check("full_pop_nopush", arb2dmem_req, 1'b0);
      advance();
      b_resp = R_NOTRDY;
      settle();
      check("full_resume", req1_req_ack, 1'b1);
      check("full_resume_addr", arb2dmem_addr, 32'h20);
      advance();

      // Reset while a transaction is outstanding; late response is spurious.
      doReset();
      setReq(0, 32'h40); b_ack = 1'b1;
      settle(); advance();
      rst = 1'b1; b_req = 2'b00; b_resp = R_OK;
      settle();
      check("rst_busy", arb_busy, 1'b0);
      check("rst_resp0", req0_resp, R_NOTRDY);
      advance();
      rst = 1'b0;
      settle();
      check("rst_late_spur", arb_spurious_resp, 1'b1);
      check("rst_late_resp0", req0_resp, R_NOTRDY);
      advance();

      // Randomized traffic against the reference model.
      doReset();
      for (int c = 0; c < 800; c++) begin
         applyStimulus(70, 45);
         settle();
         advance();
         if (e_acc) begin
            pend[e_w]  = 0;
            b_req[e_w] = 1'b0;
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
